spi_byte_engine: RTL and testbench

- Hardware SPI byte shifter for the expansion CPLD. It replaces bit-banging MOSI/SCK through successive ctrl codes.
- The ctrl-code decoder issues one command strobe per byte. The engine then drives nSS/MOSI/SCK in mode 0, samples the selected MISO line and returns the received byte.
- It sits between the ctrl-bit decode and the SPI pins, and owns those pins while enabled.

---
 rtl/spi_byte_engine.sv | 134 +++++++++++++
 tb/tb_spi_byte_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter driving nSS/MOSI/SCK for the expansion CPLD.
// One command strobe moves one byte out on MOSI and one byte in from MISO.
module spi_byte_engine #(
  parameter int DIVW = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            CMD_WR,
  input  logic [7:0]      CMD_DATA,
  input  logic [1:0]      CMD_NSS,
  input  logic            CMD_KEEP,
  input  logic [DIVW-1:0] CMD_DIV,
  input  logic [2:0]      MISO,
  output logic            MOSI,
  output logic            SCK,
  output logic [1:0]      nSS,
  output logic [7:0]      RXD,
  output logic            BUSY,
  output logic            DONE,
  output logic            OVR
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    FIN
  } state_t;

  state_t          state;
  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div_q;
  logic            keep_q;
  logic [7:0]      tx;
  logic [7:0]      rx;
  logic [2:0]      bitn;
  logic            misox;
  logic            phase_end;

  // Pick the MISO line of whichever device the registered nSS selects
  always_comb begin
    misox = (MISO[0] & ~nSS[0])
          | (MISO[1] & ~nSS[1])
          | (MISO[2] & nSS[0] & nSS[1]);
  end

  assign phase_end = (cnt == '0);

  // Transfer sequencer: every phase lasts H = div+1 cycles
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= '0;
      keep_q <= 1'b0;
      tx     <= 8'h00;
      rx     <= 8'h00;
      bitn   <= 3'd0;
      MOSI   <= 1'b0;
      SCK    <= 1'b0;
      nSS    <= 2'b11;
      RXD    <= 8'h00;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      OVR    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (CMD_WR && state != IDLE) begin
        OVR <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (CMD_WR) begin
            tx     <= CMD_DATA;
            div_q  <= CMD_DIV;
            cnt    <= CMD_DIV;
            keep_q <= CMD_KEEP;
            nSS    <= CMD_NSS;
            MOSI   <= CMD_DATA[7];
            OVR    <= 1'b0;
            bitn   <= 3'd0;
            BUSY   <= 1'b1;
            state  <= LEAD;
          end
        end
        LEAD, LOW: begin
          if (phase_end) begin
            SCK   <= 1'b1;
            rx    <= {rx[6:0], misox};
            cnt   <= div_q;
            state <= HIGH;
          end else begin
            cnt <= cnt - DIVW'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            SCK <= 1'b0;
            cnt <= div_q;
            if (bitn != 3'd7) begin
              MOSI  <= tx[6];
              tx    <= {tx[6:0], 1'b0};
              bitn  <= bitn + 3'd1;
              state <= LOW;
            end else begin
              state <= FIN;
            end
          end else begin
            cnt <= cnt - DIVW'(1);
          end
        end
        FIN: begin
          if (phase_end) begin
            RXD   <= rx;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            if (!keep_q) begin
              nSS <= 2'b11;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - DIVW'(1);
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: timing, loopback data, keep,
// overrun, dummy clocks and asynchronous abort.
module tb_spi_byte_engine;

  logic       CLK;
  logic       nRST;
  logic       CMD_WR;
  logic [7:0] CMD_DATA;
  logic [1:0] CMD_NSS;
  logic       CMD_KEEP;
  logic [3:0] CMD_DIV;
  logic [2:0] MISO;
  logic       MOSI;
  logic       SCK;
  logic [1:0] nSS;
  logic [7:0] RXD;
  logic       BUSY;
  logic       DONE;
  logic       OVR;

  logic       lb;
  logic [2:0] mval;

  int total;
  int bad;

  int         done_at;
  int         rises;
  int         rise0;
  int         rise1;
  int         fall0;
  int         nss_bad;
  int         dones;
  logic [7:0] mosi_seq;
  logic       busy1;
  logic       ovr1;
  logic       ovr_end;

  assign MISO = lb ? {mval[2], mval[1], MOSI} : mval;

  spi_byte_engine #(.DIVW(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .CMD_WR   (CMD_WR),
    .CMD_DATA (CMD_DATA),
    .CMD_NSS  (CMD_NSS),
    .CMD_KEEP (CMD_KEEP),
    .CMD_DIV  (CMD_DIV),
    .MISO     (MISO),
    .MOSI     (MOSI),
    .SCK      (SCK),
    .nSS      (nSS),
    .RXD      (RXD),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OVR      (OVR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Issue one command from a negedge and watch it until DONE.
  task automatic xfer(input logic [7:0] d, input logic [1:0] s,
                      input logic k, input logic [3:0] dv,
                      input logic [1:0] exp_nss, input int inj);
    logic prev;
    done_at  = -1;
    rises    = 0;
    rise0    = -1;
    rise1    = -1;
    fall0    = -1;
    nss_bad  = 0;
    mosi_seq = 8'h00;
    prev     = SCK;
    CMD_DATA = d;
    CMD_NSS  = s;
    CMD_KEEP = k;
    CMD_DIV  = dv;
    CMD_WR   = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      CMD_WR = (n + 1 == inj);
      if (n + 1 == inj) begin
        CMD_DATA = 8'h00;
        CMD_NSS  = ~s;
        CMD_DIV  = 4'd9;
      end
      if (n == 0) begin
        busy1 = BUSY;
        ovr1  = OVR;
      end
      if (SCK && !prev) begin
        if (rises == 0) rise0 = n;
        if (rises == 1) rise1 = n;
        rises++;
        mosi_seq = {mosi_seq[6:0], MOSI};
      end
      if (!SCK && prev && fall0 < 0) fall0 = n;
      prev = SCK;
      if (BUSY && nSS !== exp_nss) nss_bad++;
      if (DONE) begin
        done_at = n;
        break;
      end
    end
    CMD_WR  = 1'b0;
    ovr_end = OVR;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    nRST     = 1'b0;
    CMD_WR   = 1'b0;
    CMD_DATA = 8'h00;
    CMD_NSS  = 2'b11;
    CMD_KEEP = 1'b0;
    CMD_DIV  = 4'd0;
    lb       = 1'b0;
    mval     = 3'b000;
    repeat (2) @(negedge CLK);

    chk("rst_sck", 32'(SCK), 32'h0);
    chk("rst_mosi", 32'(MOSI), 32'h0);
    chk("rst_nss", 32'(nSS), 32'h3);
    chk("rst_rxd", 32'(RXD), 32'h00);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    chk("rst_ovr", 32'(OVR), 32'h0);
    nRST = 1'b1;
    @(negedge CLK);

    // A5 loopback on device 0, DIV=0
    lb   = 1'b1;
    mval = 3'b000;
    xfer(8'hA5, 2'b10, 1'b0, 4'd0, 2'b10, 0);
    chk("t1_busy1", 32'(busy1), 32'h1);
    chk("t1_rise0", rise0, 1);
    chk("t1_rises", rises, 8);
    chk("t1_mosi", 32'(mosi_seq), 32'hA5);
    chk("t1_done", done_at, 17);
    chk("t1_rxd", 32'(RXD), 32'hA5);
    chk("t1_nss", nss_bad, 0);
    chk("t1_nss_end", 32'(nSS), 32'h3);
    chk("t1_busy_end", 32'(BUSY), 32'h0);
    @(negedge CLK);
    chk("t1_done_pulse", 32'(DONE), 32'h0);

    // H=4, device 1 with MISO tied high
    lb   = 1'b0;
    mval = 3'b010;
    xfer(8'h3C, 2'b01, 1'b0, 4'd3, 2'b01, 0);
    chk("t2_rise0", rise0, 4);
    chk("t2_high", fall0 - rise0, 4);
    chk("t2_period", rise1 - rise0, 8);
    chk("t2_rises", rises, 8);
    chk("t2_mosi", 32'(mosi_seq), 32'h3C);
    chk("t2_done", done_at, 68);
    chk("t2_rxd", 32'(RXD), 32'hFF);
    chk("t2_nss", nss_bad, 0);
    chk("t2_nss_end", 32'(nSS), 32'h3);

    // KEEP byte followed by a command in the DONE cycle
    lb   = 1'b1;
    mval = 3'b000;
    xfer(8'h5A, 2'b10, 1'b1, 4'd0, 2'b10, 0);
    chk("t3_done_a", done_at, 17);
    chk("t3_rxd_a", 32'(RXD), 32'h5A);
    chk("t3_nss_a", nss_bad, 0);
    chk("t3_keep_nss", 32'(nSS), 32'h2);
    chk("t3_busy_gap", 32'(BUSY), 32'h0);
    xfer(8'hC3, 2'b10, 1'b0, 4'd0, 2'b10, 0);
    chk("t3_busy1", 32'(busy1), 32'h1);
    chk("t3_done_b", done_at, 17);
    chk("t3_rxd_b", 32'(RXD), 32'hC3);
    chk("t3_nss_b", nss_bad, 0);
    chk("t3_nss_end", 32'(nSS), 32'h3);

    // Overrun: command injected at E0+5
    xfer(8'h96, 2'b10, 1'b0, 4'd0, 2'b10, 5);
    chk("t4_done", done_at, 17);
    chk("t4_rxd", 32'(RXD), 32'h96);
    chk("t4_mosi", 32'(mosi_seq), 32'h96);
    chk("t4_nss", nss_bad, 0);
    chk("t4_ovr", 32'(ovr_end), 32'h1);
    xfer(8'h11, 2'b10, 1'b0, 4'd0, 2'b10, 0);
    chk("t4_ovr_clr", 32'(ovr1), 32'h0);
    chk("t4_rxd2", 32'(RXD), 32'h11);

    // Dummy clocks with nothing selected
    lb   = 1'b0;
    mval = 3'b001;
    xfer(8'hFF, 2'b11, 1'b0, 4'd0, 2'b11, 0);
    chk("t5_rises", rises, 8);
    chk("t5_done", done_at, 17);
    chk("t5_rxd", 32'(RXD), 32'h00);
    chk("t5_nss", nss_bad, 0);
    chk("t5_nss_end", 32'(nSS), 32'h3);

    // Asynchronous abort at E0+7
    lb       = 1'b1;
    mval     = 3'b000;
    CMD_DATA = 8'hE7;
    CMD_NSS  = 2'b10;
    CMD_KEEP = 1'b1;
    CMD_DIV  = 4'd0;
    CMD_WR   = 1'b1;
    @(posedge CLK);
    #1 CMD_WR = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    chk("t6_busy_pre", 32'(BUSY), 32'h1);
    #1 nRST = 1'b0;
    #1;
    chk("t6_sck", 32'(SCK), 32'h0);
    chk("t6_nss", 32'(nSS), 32'h3);
    chk("t6_busy", 32'(BUSY), 32'h0);
    @(negedge CLK);
    nRST  = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    chk("t6_no_done", dones, 0);
    chk("t6_rxd", 32'(RXD), 32'h00);
    chk("t6_idle", 32'(BUSY), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
